rename_tag_allocator: RTL and testbench
=======================================

// Module: rename_tag_allocator
// PURPOSE
//  Free-list scheduler for the physical rename tags (rn) used by the dual-issue resolver stage.
//  - Hands out up to two tags per cycle, in slot order; reclaims up to two tags per cycle from commit.
//  - Keeps one branch checkpoint so speculative (tagged) allocations can be rolled back.
//  - Drives the resolver stall when a request pair cannot be fully served.
// PARAMETERS
//  TAG_WIDTH  6   width of a rename tag; tag 0 = "no rename", never allocated
//  NUM_TAGS   64  tag space, 2**TAG_WIDTH; allocatable tags are 1..NUM_TAGS-1
// PORTS
//  i_clock          in   1          single clock, rising edge
//  i_reset          in   1          asynchronous, active-low reset
//  i_halt           in   1          1 = suppress all allocation this cycle
//  i_alloc_req[2]   in   1 each     slot k needs a tag (writes && rd!=0)
//  o_alloc_tag[2]   out  TAG_WIDTH  tag offered to slot k (comb.); 0 when not granted
//  o_alloc_ok       out  1          pair granted this cycle (comb.)
//  o_stall          out  1          requests pending but not granted (comb.)
//  i_free_valid[2]  in   1 each     commit returns a tag on port k
//  i_free_tag[2]    in   TAG_WIDTH  returned tag
//  i_checkpoint     in   1          snapshot free list after this cycle's allocation
//  i_ckpt_release   in   1          branch resolved correct; drop snapshot
//  i_rollback       in   1          mispredict; restore snapshot
//  o_ckpt_active    out  1          a snapshot is held
//  o_free_count     out  TAG_WIDTH  number of free tags
//  o_panic          out  1          sticky error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Storage: circular buffer of NUM_TAGS entries; rptr/wptr are TAG_WIDTH+1 bits (wrap bit).
//  - Reset (async, i_reset=0):
//    - entries[0..NUM_TAGS-2] = tags 1..NUM_TAGS-1; rptr=0; wptr=NUM_TAGS-1; count=NUM_TAGS-1.
//    - o_ckpt_active=0, o_panic=0, o_free_count=63; o_alloc_ok, o_stall follow comb. rules below.
//  - Grant: n = req[0]+req[1]; o_alloc_ok = !i_halt && !i_rollback && count>=n (all-or-nothing).
//    - o_stall = (n!=0) && !o_alloc_ok.
//    - n=0 -> o_alloc_ok=1, no state change.
//  - Tag order:
//    - slot0 gets entries[rptr].
//    - slot1 gets entries[rptr+1] if req[0], else entries[rptr].
//    - Non-requesting or ungranted slot outputs 0. rptr += n at edge when granted.
//  - Free: valid ports are compacted (port0 first), written at wptr, wptr += popcount; always accepted.
//  - Count: count_next = count - granted_n + freed_n.
//    - Same-cycle frees are not bypassed to grant; they are visible next cycle.
//  - Checkpoint:
//    - i_checkpoint && !o_ckpt_active -> snap_rptr <= rptr_next; o_ckpt_active <= 1.
//    - i_checkpoint while active is ignored.
//  - Release: i_ckpt_release clears o_ckpt_active. Release and checkpoint in the same cycle -> new snapshot taken.
//  - Rollback: i_rollback && o_ckpt_active -> rptr <= snap_rptr; count <= wptr_next - snap_rptr.
//    - o_ckpt_active <= 0. The same cycle's frees still apply; allocation is blocked (o_alloc_ok=0).
//    - i_rollback with no active snapshot: no effect other than blocking allocation that cycle.
//  - Wrap-around: pointer difference is taken mod 2*NUM_TAGS. The buffer never overfills because only allocated tags are returned.
// CONFIGURATION
//  RENAME_FREE_CHECK_EN defined:
//    - Keeps a NUM_TAGS-bit allocated map plus a snapshot copy.
//    - Alloc sets the live bit. Free clears both the live and snapshot bits.
//    - Rollback: live <= snapshot & ~freed_this_cycle.
//    - A free of tag 0, of an unallocated tag, or of the same tag on both ports -> that free is dropped and o_panic <= 1 (sticky to reset).
//  RENAME_FREE_CHECK_EN undefined: no map; all frees accepted; o_panic tied 0.
// STRUCTURE
//  - pkg_defines: typedef logic [TAG_WIDTH-1:0] rename_tag_t; localparam rename_tag_t TAG_NONE = '0.
//  - Sub-module rename_free_fifo: 2-read/2-write circular buffer holding pointers and reset fill.
//    Control (grant, count, checkpoint, check map) stays in the top module.
// TESTING
//  1. Reset release -> o_free_count=63; req={1,1} -> tags 1,2, ok=1; next cycle count=61.
//  2. req={0,1} only -> slot1 gets the head tag, o_alloc_tag[0]=0; req with i_halt=1 -> ok=0, stall=1.
//  3. Drain to count=1, then req={1,1} -> ok=0, stall=1, no pointer move.
//     Same cycle free tag 5 -> next cycle pair granted (5 plus the former head).
//  4. Checkpoint at count=40; allocate 6 tags; free 2; rollback -> count=42, ckpt_active=0.
//     Next grant reissues the first post-checkpoint tag.
//  5. 200 cycles of alloc 2 / free 2 -> pointers wrap; tags stay unique; count constant.
//  6. With RENAME_FREE_CHECK_EN: free tag 0, or free tag 7 twice -> o_panic=1, count unchanged.
//     Without the macro -> o_panic stays 0.

Source files
------------

// File: rtl/rename_tag_allocator_pkg.sv
// rtl/rename_tag_allocator_pkg.sv - shared types and helpers for the rename tag allocator
// Tag 0 means "no rename" and is never placed in the free list.
package rename_tag_allocator_pkg;

  localparam int TAG_WIDTH = 6;
  localparam int NUM_TAGS  = 1 << TAG_WIDTH;

  typedef logic [TAG_WIDTH-1:0] rename_tag_t;
  // Free-list pointers carry one extra wrap bit so full and empty differ.
  typedef logic [TAG_WIDTH:0]   ptr_t;
  typedef logic [NUM_TAGS-1:0]  tag_map_t;

  localparam rename_tag_t TAG_NONE = '0;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  // One-hot map bit for a tag; TAG_NONE maps to nothing.
  function automatic tag_map_t tag_mask(input rename_tag_t t);
    return (tag_map_t'(1) << t) & ~tag_map_t'(1);
  endfunction

endpackage

// File: rtl/rename_tag_allocator_if.sv
// rtl/rename_tag_allocator_if.sv - allocation, free and checkpoint signals of the rename tag allocator
// master: resolver/commit side (drives i_*), slave: allocator (drives o_*).
//   i_halt, i_alloc_req[1:0]          allocation request per slot, halt suppresses all grants
//   o_alloc_tag[1:0], o_alloc_ok      offered tags and pair grant
//   o_stall                           requests pending but not granted
//   i_free_valid[1:0], i_free_tag     tags returned by commit
//   i_checkpoint, i_ckpt_release, i_rollback, o_ckpt_active
//   o_free_count, o_panic
interface rename_tag_allocator_if;
  import rename_tag_allocator_pkg::*;

  logic              i_halt;
  logic [1:0]        i_alloc_req;
  rename_tag_t [1:0] o_alloc_tag;
  logic              o_alloc_ok;
  logic              o_stall;
  logic [1:0]        i_free_valid;
  rename_tag_t [1:0] i_free_tag;
  logic              i_checkpoint;
  logic              i_ckpt_release;
  logic              i_rollback;
  logic              o_ckpt_active;
  rename_tag_t       o_free_count;
  logic              o_panic;

  modport master (
    output i_halt, i_alloc_req, i_free_valid, i_free_tag,
           i_checkpoint, i_ckpt_release, i_rollback,
    input  o_alloc_tag, o_alloc_ok, o_stall, o_ckpt_active, o_free_count, o_panic
  );

  modport slave (
    input  i_halt, i_alloc_req, i_free_valid, i_free_tag,
           i_checkpoint, i_ckpt_release, i_rollback,
    output o_alloc_tag, o_alloc_ok, o_stall, o_ckpt_active, o_free_count, o_panic
  );

endinterface

// File: rtl/rename_free_fifo.sv
// rtl/rename_free_fifo.sv - 2-read/2-write circular free list of rename tags
// Ports: i_clock, i_reset (async, active-low)
//   rd_count    tags consumed from the head this cycle (0..2)
//   rd_load     replace rptr with rd_load_ptr (checkpoint restore)
//   wr_en/wr_tag returned tags; enabled ports are packed at wptr, port 0 first
//   rd_tag      entries[rptr], entries[rptr+1]
//   rptr/wptr   pointers with wrap bit
module rename_free_fifo
  import rename_tag_allocator_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [1:0]        rd_count,
  input  logic              rd_load,
  input  ptr_t              rd_load_ptr,
  input  logic [1:0]        wr_en,
  input  rename_tag_t [1:0] wr_tag,
  output rename_tag_t [1:0] rd_tag,
  output ptr_t              rptr,
  output ptr_t              wptr
);

  typedef logic [TAG_WIDTH-1:0] idx_t;

  rename_tag_t entries [NUM_TAGS];
  idx_t        ridx;
  idx_t        widx;

  assign ridx      = rptr[TAG_WIDTH-1:0];
  assign widx      = wptr[TAG_WIDTH-1:0];
  assign rd_tag[0] = entries[ridx];
  assign rd_tag[1] = entries[ridx + idx_t'(1)];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // Entry i holds tag i+1; the last entry wraps to 0 and sits outside the free region.
      for (int i = 0; i < NUM_TAGS; i++) entries[i] <= rename_tag_t'(i + 1);
      rptr <= '0;
      wptr <= ptr_t'(NUM_TAGS - 1);
    end else begin
      if (wr_en[0]) entries[widx] <= wr_tag[0];
      if (wr_en[1]) entries[widx + idx_t'(wr_en[0])] <= wr_tag[1];
      rptr <= rd_load ? rd_load_ptr : rptr + ptr_t'(rd_count);
      wptr <= wptr + ptr_t'(popcount2(wr_en));
    end
  end

endmodule

// File: rtl/rename_tag_allocator.sv
// rtl/rename_tag_allocator.sv - dual-issue rename tag free-list scheduler with one branch checkpoint
// Ports: i_clock, i_reset (async, active-low), bus (rename_tag_allocator_if.slave).
// Optional macro RENAME_FREE_CHECK_EN: track allocated tags, drop illegal frees and raise sticky o_panic.
module rename_tag_allocator
  import rename_tag_allocator_pkg::*;
(
  input logic                   i_clock,
  input logic                   i_reset,
  rename_tag_allocator_if.slave bus
);

  logic [1:0]        req;
  logic [1:0]        req_n;
  logic [1:0]        grant_n;
  logic              alloc_ok;
  rename_tag_t [1:0] head;
  rename_tag_t [1:0] alloc_tag;
  ptr_t              rptr;
  ptr_t              wptr;
  ptr_t              rptr_next;
  ptr_t              count;
  ptr_t              snap_rptr;
  logic              ckpt_active;
  logic              do_rollback;
  logic              take_ckpt;
  logic [1:0]        free_en;

  assign req     = bus.i_alloc_req;
  assign req_n   = popcount2(req);
  // Free count is the pointer distance, so a restore of rptr recomputes it for free.
  assign count   = wptr - rptr;
  assign alloc_ok  = !bus.i_halt && !bus.i_rollback && (count >= ptr_t'(req_n));
  assign grant_n   = alloc_ok ? req_n : 2'd0;
  assign rptr_next = rptr + ptr_t'(grant_n);

  assign alloc_tag[0] = (alloc_ok && req[0]) ? head[0] : TAG_NONE;
  assign alloc_tag[1] = (alloc_ok && req[1]) ? (req[0] ? head[1] : head[0]) : TAG_NONE;

  assign bus.o_alloc_tag   = alloc_tag;
  assign bus.o_alloc_ok    = alloc_ok;
  assign bus.o_stall       = (req_n != 2'd0) && !alloc_ok;
  assign bus.o_free_count  = count[TAG_WIDTH-1:0];
  assign bus.o_ckpt_active = ckpt_active;

  assign do_rollback = bus.i_rollback && ckpt_active;
  // A release in the same cycle frees the slot for the new snapshot.
  assign take_ckpt   = bus.i_checkpoint && (!ckpt_active || bus.i_ckpt_release) && !do_rollback;

  rename_free_fifo u_free_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .rd_count    (grant_n),
    .rd_load     (do_rollback),
    .rd_load_ptr (snap_rptr),
    .wr_en       (free_en),
    .wr_tag      (bus.i_free_tag),
    .rd_tag      (head),
    .rptr        (rptr),
    .wptr        (wptr)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ckpt_active <= 1'b0;
      snap_rptr   <= '0;
    end else if (do_rollback) begin
      ckpt_active <= 1'b0;
    end else if (take_ckpt) begin
      ckpt_active <= 1'b1;
      snap_rptr   <= rptr_next;
    end else if (bus.i_ckpt_release) begin
      ckpt_active <= 1'b0;
    end
  end

`ifdef RENAME_FREE_CHECK_EN
  tag_map_t live_map;
  tag_map_t snap_map;
  tag_map_t alloc_mask;
  tag_map_t free_mask;
  tag_map_t live_after;
  logic     panic;

  // A duplicate on port 1 is dropped even when port 0 was itself illegal.
  always_comb begin
    free_en    = 2'b00;
    free_en[0] = bus.i_free_valid[0] && (bus.i_free_tag[0] != TAG_NONE)
                 && live_map[bus.i_free_tag[0]];
    free_en[1] = bus.i_free_valid[1] && (bus.i_free_tag[1] != TAG_NONE)
                 && live_map[bus.i_free_tag[1]]
                 && !(bus.i_free_valid[0] && (bus.i_free_tag[1] == bus.i_free_tag[0]));
  end

  assign alloc_mask = tag_mask(alloc_tag[0]) | tag_mask(alloc_tag[1]);
  assign free_mask  = (free_en[0] ? tag_mask(bus.i_free_tag[0]) : '0)
                    | (free_en[1] ? tag_mask(bus.i_free_tag[1]) : '0);
  assign live_after = (live_map | alloc_mask) & ~free_mask;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      live_map <= '0;
      snap_map <= '0;
      panic    <= 1'b0;
    end else begin
      live_map <= do_rollback ? (snap_map & ~free_mask) : live_after;
      snap_map <= take_ckpt ? live_after : (snap_map & ~free_mask);
      panic    <= panic | (|(bus.i_free_valid & ~free_en));
    end
  end

  assign bus.o_panic = panic;
`else
  assign free_en     = bus.i_free_valid;
  assign bus.o_panic = 1'b0;
`endif

endmodule

// File: tb/tb_rename_tag_allocator.sv
// tb/tb_rename_tag_allocator.sv - self-checking bench for rename_tag_allocator
module tb_rename_tag_allocator;
  import rename_tag_allocator_pkg::*;

  logic i_clock = 1'b0;
  logic i_reset;
  always #5 i_clock = ~i_clock;

  rename_tag_allocator_if bus ();

  rename_tag_allocator dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: free list as an ordered queue of tags.
  rename_tag_t free_q[$];   // free tags in hand-out order
  rename_tag_t since_q[$];  // tags handed out since the live checkpoint
  rename_tag_t live_q[$];   // committed-side tags the bench may return
  bit          allocated[NUM_TAGS];
  bit          m_active;
  bit          m_panic;
  rename_tag_t obs_tag0;
  rename_tag_t obs_tag1;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, observed, expected);
    end
  endtask

  task automatic idle();
    bus.i_halt         = 1'b0;
    bus.i_alloc_req    = 2'b00;
    bus.i_free_valid   = 2'b00;
    bus.i_free_tag[0]  = TAG_NONE;
    bus.i_free_tag[1]  = TAG_NONE;
    bus.i_checkpoint   = 1'b0;
    bus.i_ckpt_release = 1'b0;
    bus.i_rollback     = 1'b0;
  endtask

  task automatic take_live(input rename_tag_t t);
    foreach (live_q[i]) if (live_q[i] == t) begin
      live_q.delete(i);
      return;
    end
  endtask

  task automatic pick_free(output rename_tag_t t);
    int idx;
    idx = $urandom_range(live_q.size() - 1);
    t   = live_q[idx];
    live_q.delete(idx);
  endtask

  // Inputs must already be driven; checks outputs, then advances one clock.
  task automatic run_cycle();
    int          n;
    bit          ok;
    rename_tag_t t0;
    rename_tag_t t1;
    rename_tag_t fr[$];
    bit          spec;

    n  = int'(bus.i_alloc_req[0]) + int'(bus.i_alloc_req[1]);
    ok = !bus.i_halt && !bus.i_rollback && (free_q.size() >= n);
    t0 = TAG_NONE;
    t1 = TAG_NONE;
    if (ok && bus.i_alloc_req[0]) t0 = free_q[0];
    if (ok && bus.i_alloc_req[1]) t1 = bus.i_alloc_req[0] ? free_q[1] : free_q[0];

    @(negedge i_clock);
    obs_tag0 = bus.o_alloc_tag[0];
    obs_tag1 = bus.o_alloc_tag[1];
    check("alloc_ok",    bus.o_alloc_ok, ok);
    check("stall",       bus.o_stall, (n != 0) && !ok);
    check("alloc_tag0",  bus.o_alloc_tag[0], t0);
    check("alloc_tag1",  bus.o_alloc_tag[1], t1);
    check("free_count",  bus.o_free_count, free_q.size());
    check("ckpt_active", bus.o_ckpt_active, m_active);
    check("panic",       bus.o_panic, m_panic);

    // Frees are judged against the allocation state before this cycle's grants.
    for (int k = 0; k < 2; k++) begin
      if (bus.i_free_valid[k]) begin
`ifdef RENAME_FREE_CHECK_EN
        if (bus.i_free_tag[k] == TAG_NONE || !allocated[bus.i_free_tag[k]] ||
            (k == 1 && bus.i_free_valid[0] && bus.i_free_tag[0] == bus.i_free_tag[1])) begin
          m_panic = 1'b1;
          continue;
        end
`endif
        fr.push_back(bus.i_free_tag[k]);
      end
    end

    spec = m_active && !bus.i_ckpt_release;
    if (t0 != TAG_NONE) begin
      void'(free_q.pop_front());
      allocated[t0] = 1'b1;
      if (spec) since_q.push_back(t0); else live_q.push_back(t0);
    end
    if (t1 != TAG_NONE) begin
      void'(free_q.pop_front());
      allocated[t1] = 1'b1;
      if (spec) since_q.push_back(t1); else live_q.push_back(t1);
    end
    foreach (fr[i]) begin
      free_q.push_back(fr[i]);
      allocated[fr[i]] = 1'b0;
    end

    if (bus.i_rollback && m_active) begin
      for (int i = since_q.size() - 1; i >= 0; i--) begin
        allocated[since_q[i]] = 1'b0;
        free_q.push_front(since_q[i]);
      end
      since_q.delete();
      m_active = 1'b0;
    end else if (bus.i_checkpoint && (!m_active || bus.i_ckpt_release)) begin
      foreach (since_q[i]) live_q.push_back(since_q[i]);
      since_q.delete();
      m_active = 1'b1;
    end else if (bus.i_ckpt_release) begin
      foreach (since_q[i]) live_q.push_back(since_q[i]);
      since_q.delete();
      m_active = 1'b0;
    end

    @(posedge i_clock);
    #1;
  endtask

  initial begin
    rename_tag_t ta;
    rename_tag_t tb;
    rename_tag_t first_spec;
    int          c0;

    idle();
    i_reset = 1'b1;
    #2 i_reset = 1'b0;
    @(negedge i_clock);
    check("reset_free_count",  bus.o_free_count, 63);
    check("reset_ckpt_active", bus.o_ckpt_active, 0);
    check("reset_panic",       bus.o_panic, 0);
    check("reset_alloc_ok",    bus.o_alloc_ok, 1);
    check("reset_stall",       bus.o_stall, 0);
    @(posedge i_clock);
    #1 i_reset = 1'b1;

    for (int t = 1; t < NUM_TAGS; t++) free_q.push_back(rename_tag_t'(t));
    m_active = 1'b0;
    m_panic  = 1'b0;

    // Pair grant straight out of reset.
    idle(); bus.i_alloc_req = 2'b11; run_cycle();
    check("first_tag0", obs_tag0, 1);
    check("first_tag1", obs_tag1, 2);
    check("first_count", bus.o_free_count, 61);

    // Slot 1 alone takes the head; halt blocks a pair.
    idle(); bus.i_alloc_req = 2'b10; run_cycle();
    check("slot1_only_tag0", obs_tag0, 0);
    check("slot1_only_tag1", obs_tag1, 3);
    idle(); bus.i_alloc_req = 2'b11; bus.i_halt = 1'b1; run_cycle();

    // Drain to one free tag; a pair then stalls while tag 5 returns.
    while (free_q.size() > 1) begin
      idle();
      bus.i_alloc_req = (free_q.size() >= 3) ? 2'b11 : 2'b01;
      run_cycle();
    end
    idle(); bus.i_alloc_req = 2'b11; bus.i_free_valid = 2'b01;
    bus.i_free_tag[0] = rename_tag_t'(5); take_live(rename_tag_t'(5));
    run_cycle();
    idle(); bus.i_alloc_req = 2'b11; run_cycle();
    check("refill_tag1", obs_tag1, 5);

    // Return tags until 40 are free.
    while (free_q.size() < 40) begin
      idle(); bus.i_free_valid = 2'b11;
      bus.i_free_tag[0] = live_q.pop_front();
      bus.i_free_tag[1] = live_q.pop_front();
      run_cycle();
    end

    // Checkpoint, speculate 6 tags, commit 2 older tags, roll back.
    idle(); bus.i_checkpoint = 1'b1; run_cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.i_alloc_req = 2'b11; run_cycle();
    end
    idle(); bus.i_free_valid = 2'b11;
    bus.i_free_tag[0] = live_q.pop_front();
    bus.i_free_tag[1] = live_q.pop_front();
    run_cycle();
    first_spec = since_q[0];
    idle(); bus.i_rollback = 1'b1; run_cycle();
    check("rollback_count", bus.o_free_count, 42);
    check("rollback_ckpt_active", bus.o_ckpt_active, 0);
    idle(); bus.i_alloc_req = 2'b01; run_cycle();
    check("reissue_tag0", obs_tag0, first_spec);

    // Steady alloc 2 / free 2 wraps the pointers many times.
    c0 = free_q.size();
    for (int i = 0; i < 200; i++) begin
      idle(); bus.i_alloc_req = 2'b11; bus.i_free_valid = 2'b11;
      bus.i_free_tag[0] = live_q.pop_front();
      bus.i_free_tag[1] = live_q.pop_front();
      run_cycle();
    end
    check("wrap_count_const", bus.o_free_count, c0);

    // Random mix of requests, halts, frees and checkpoint control.
    for (int c = 0; c < 400; c++) begin
      int op;
      idle();
      bus.i_alloc_req = 2'($urandom);
      bus.i_halt      = ($urandom_range(9) == 0);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(1) == 0 && live_q.size() > 0) begin
          pick_free(ta);
          bus.i_free_valid[k] = 1'b1;
          bus.i_free_tag[k]   = ta;
        end
      end
      op = $urandom_range(15);
      case (op)
        0: bus.i_checkpoint = 1'b1;
        1: bus.i_ckpt_release = 1'b1;
        2: bus.i_rollback = 1'b1;
        3: begin bus.i_checkpoint = 1'b1; bus.i_ckpt_release = 1'b1; end
        default: ;
      endcase
      run_cycle();
    end
    idle(); bus.i_ckpt_release = 1'b1; run_cycle();

`ifdef RENAME_FREE_CHECK_EN
    c0 = free_q.size();
    idle(); bus.i_free_valid = 2'b01; bus.i_free_tag[0] = TAG_NONE; run_cycle();
    check("tag0_free_panic", bus.o_panic, 1);
    check("tag0_free_count", bus.o_free_count, c0);
    if (live_q.size() == 0) begin
      idle(); bus.i_alloc_req = 2'b01; run_cycle();
    end
    tb = live_q.pop_front();
    idle(); bus.i_free_valid = 2'b01; bus.i_free_tag[0] = tb; run_cycle();
    c0 = free_q.size();
    idle(); bus.i_free_valid = 2'b01; bus.i_free_tag[0] = tb; run_cycle();
    check("double_free_count", bus.o_free_count, c0);
    check("double_free_panic", bus.o_panic, 1);
`else
    c0 = free_q.size();
    idle(); bus.i_free_valid = 2'b00; run_cycle();
    check("no_check_panic", bus.o_panic, 0);
    check("no_check_count", bus.o_free_count, c0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
